// File: rtl/fp_operand_fifo.sv
// Buffered FIFO for floating-point operands with head-entry field split and optional classification.
// Define FP_CLASSIFY_EN to build the out_is_* classification logic; otherwise those flags are tied to 0.
module fp_operand_fifo #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned W    = 1 + EXP_W + MAN_W,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exponent,
    output logic [MAN_W-1:0] out_mantissa,
    output logic             out_is_zero,
    output logic             out_is_inf,
    output logic             out_is_nan,
    output logic             out_is_denorm,
    output logic [CW-1:0]    count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic [W-1:0]  head;

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != CW'(0));
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Pointers and occupancy; flush wins over any handshake in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= PW'(0);
            rd_ptr <= PW'(0);
            count  <= CW'(0);
        end else if (flush) begin
            wr_ptr <= PW'(0);
            rd_ptr <= PW'(0);
            count  <= CW'(0);
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately unreset; only valid entries are ever presented.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= in_data;
    end

    assign head = mem[rd_ptr];

    always_comb begin
        out_sign     = 1'b0;
        out_exponent = '0;
        out_mantissa = '0;
        if (out_valid) begin
            out_sign     = head[W-1];
            out_exponent = head[W-2:MAN_W];
            out_mantissa = head[MAN_W-1:0];
        end
    end

`ifdef FP_CLASSIFY_EN
    logic exp_zero;
    logic exp_ones;
    logic man_zero;

    assign exp_zero = (out_exponent == '0);
    assign exp_ones = &out_exponent;
    assign man_zero = (out_mantissa == '0);

    // Fields are already zeroed when empty, so gate flags on out_valid to keep them low too.
    always_comb begin
        out_is_zero   = 1'b0;
        out_is_denorm = 1'b0;
        out_is_inf    = 1'b0;
        out_is_nan    = 1'b0;
        if (out_valid) begin
            out_is_zero   = exp_zero && man_zero;
            out_is_denorm = exp_zero && !man_zero;
            out_is_inf    = exp_ones && man_zero;
            out_is_nan    = exp_ones && !man_zero;
        end
    end
`else
    assign out_is_zero   = 1'b0;
    assign out_is_inf    = 1'b0;
    assign out_is_nan    = 1'b0;
    assign out_is_denorm = 1'b0;
`endif

endmodule

// File: tb/tb_fp_operand_fifo.sv
// Directed self-checking bench for fp_operand_fifo (single precision plus a half-precision instance).
`timescale 1ns/1ps
module tb_fp_operand_fifo;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [7:0]  out_exponent;
    logic [22:0] out_mantissa;
    logic        out_is_zero;
    logic        out_is_inf;
    logic        out_is_nan;
    logic        out_is_denorm;
    logic [2:0]  count;

    logic        h_flush;
    logic        h_in_valid;
    logic        h_in_ready;
    logic [15:0] h_in_data;
    logic        h_out_valid;
    logic        h_out_ready;
    logic        h_out_sign;
    logic [4:0]  h_out_exponent;
    logic [9:0]  h_out_mantissa;
    logic        h_is_zero;
    logic        h_is_inf;
    logic        h_is_nan;
    logic        h_is_denorm;
    logic [2:0]  h_count;

    int n_checks;
    int n_errors;

    fp_operand_fifo dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exponent(out_exponent), .out_mantissa(out_mantissa),
        .out_is_zero(out_is_zero), .out_is_inf(out_is_inf),
        .out_is_nan(out_is_nan), .out_is_denorm(out_is_denorm),
        .count(count)
    );

    fp_operand_fifo #(.EXP_W(5), .MAN_W(10), .DEPTH(4)) dut_h (
        .clk(clk), .reset(reset), .flush(h_flush),
        .in_valid(h_in_valid), .in_ready(h_in_ready), .in_data(h_in_data),
        .out_valid(h_out_valid), .out_ready(h_out_ready),
        .out_sign(h_out_sign), .out_exponent(h_out_exponent), .out_mantissa(h_out_mantissa),
        .out_is_zero(h_is_zero), .out_is_inf(h_is_inf),
        .out_is_nan(h_is_nan), .out_is_denorm(h_is_denorm),
        .count(h_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] head_word();
        return {out_sign, out_exponent, out_mantissa};
    endfunction

    function automatic logic [3:0] flags();
        return {out_is_zero, out_is_denorm, out_is_inf, out_is_nan};
    endfunction

    logic [31:0] cls_word [4];
    logic [3:0]  cls_flag [4];

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 32'h0;
        out_ready   = 1'b0;
        h_flush     = 1'b0;
        h_in_valid  = 1'b0;
        h_in_data   = 16'h0;
        h_out_ready = 1'b0;
        cls_word[0] = 32'h00000000; cls_flag[0] = 4'b1000;
        cls_word[1] = 32'h00000001; cls_flag[1] = 4'b0100;
        cls_word[2] = 32'h7F800000; cls_flag[2] = 4'b0010;
        cls_word[3] = 32'h7FC00000; cls_flag[3] = 4'b0001;
`ifndef FP_CLASSIFY_EN
        for (int i = 0; i < 4; i++) cls_flag[i] = 4'b0000;
`endif
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_fields", 64'(head_word()), 64'd0);
        check("rst_flags", 64'(flags()), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        // Single word
        in_valid = 1'b1;
        in_data  = 32'h3F800000;
        tick();
        in_valid = 1'b0;
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_sign", 64'(out_sign), 64'd0);
        check("single_exp", 64'(out_exponent), 64'h7F);
        check("single_man", 64'(out_mantissa), 64'd0);
        check("single_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("single_pop_count", 64'(count), 64'd0);
        check("single_pop_valid", 64'(out_valid), 64'd0);
        check("single_pop_exp", 64'(out_exponent), 64'd0);

        // Fill and order
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            check("fill_in_ready", 64'(in_ready), (i <= 4) ? 64'd1 : 64'd0);
            tick();
        end
        in_valid = 1'b0;
        check("fill_count", 64'(count), 64'd4);
        check("fill_full", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_word", 64'(head_word()), 64'(i));
            if (i == 2) check("drain_ready_back", 64'(in_ready), 64'd1);
            tick();
        end
        out_ready = 1'b0;
        check("drain_empty", 64'(out_valid), 64'd0);

        // Sustained push+pop at count=2 with pointer wrap
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(100 + i);
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_data = 32'(102 + k);
            check("stream_count", 64'(count), 64'd2);
            check("stream_word", 64'(head_word()), 64'(100 + k));
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("stream_tail", 64'(head_word()), 64'(110 + k));
            tick();
        end
        out_ready = 1'b0;
        check("stream_empty", 64'(count), 64'd0);

        // Classification
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = cls_word[i];
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("class_word", 64'(head_word()), 64'(cls_word[i]));
            check("class_flags", 64'(flags()), 64'(cls_flag[i]));
            tick();
        end
        out_ready = 1'b0;
        check("class_empty_flags", 64'(flags()), 64'd0);

        // Flush beats a simultaneous push
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(200 + i);
            tick();
        end
        check("flush_pre_count", 64'(count), 64'd3);
        flush    = 1'b1;
        in_data  = 32'hDEADBEEF;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        in_valid = 1'b1;
        in_data  = 32'h40490FDB;
        tick();
        in_valid = 1'b0;
        check("flush_next_word", 64'(head_word()), 64'h40490FDB);
        check("flush_next_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Asynchronous reset mid-cycle
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(300 + i);
            tick();
        end
        in_valid = 1'b0;
        check("arst_pre_count", 64'(count), 64'd2);
        #2 reset = 1'b1;
        #1;
        check("arst_count", 64'(count), 64'd0);
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        #1 reset = 1'b0;
        tick();
        in_valid = 1'b1;
        in_data  = 32'hC0000000;
        tick();
        in_valid = 1'b0;
        check("arst_after_word", 64'(head_word()), 64'hC0000000);
        check("arst_after_count", 64'(count), 64'd1);

        // Half-precision fill and order
        for (int i = 1; i <= 5; i++) begin
            h_in_valid = 1'b1;
            h_in_data  = 16'h3C00 + 16'(i);
            check("h_fill_in_ready", 64'(h_in_ready), (i <= 4) ? 64'd1 : 64'd0);
            tick();
        end
        h_in_valid = 1'b0;
        check("h_fill_count", 64'(h_count), 64'd4);
        h_out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("h_drain_word", 64'({h_out_sign, h_out_exponent, h_out_mantissa}),
                  64'(16'h3C00 + 16'(i)));
            check("h_drain_exp", 64'(h_out_exponent), 64'h0F);
            tick();
        end
        h_out_ready = 1'b0;
        check("h_drain_empty", 64'(h_out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp_operand_fifo.md
# fp_operand_fifo

Parametrised buffered operand register for the floating-point adder datapath. Accepts packed IEEE-754-style words through a valid/ready handshake and stores up to DEPTH of them in order. Presents the head entry already split into sign, exponent and mantissa, with optional special-value classification flags. Sits between the operand source and the adder's alignment stage, and replaces single-entry operand capture wherever back-pressure or queuing is needed.

## Interface
Parameters:
- EXP_W, 8, exponent field width
- MAN_W, 23, stored mantissa field width (no hidden bit)
- DEPTH, 4, number of entries; power of two, at least 2
- Derived: W = 1 + EXP_W + MAN_W; CW = $clog2(DEPTH+1)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of all entries
- in_valid  in  1  producer has a word on in_data
- in_ready  out  1  FIFO can accept a word
- in_data  in  W  packed word: [W-1] sign, [W-2:MAN_W] exponent, [MAN_W-1:0] mantissa
- out_valid  out  1  head entry is valid
- out_ready  in  1  consumer takes the head entry
- out_sign  out  1  sign of the head entry
- out_exponent  out  EXP_W  exponent of the head entry
- out_mantissa  out  MAN_W  mantissa of the head entry
- out_is_zero, out_is_inf, out_is_nan, out_is_denorm  out  1 each  classification of the head entry
- count  out  CW  number of stored entries

## Operation
- Storage is a circular buffer of DEPTH words with a write pointer, a read pointer and an occupancy counter. Pointers wrap modulo DEPTH.
- Push: in_valid && in_ready. Writes in_data at wr_ptr, then increments wr_ptr.
- Pop: out_valid && out_ready. Increments rd_ptr.
- in_ready = (count != DEPTH). There is no bypass: when the FIFO is full, a push is refused even if a pop happens in the same cycle.
- out_valid = (count != 0).
- Push and pop in the same cycle leave count unchanged. Push alone adds 1 to count. Pop alone subtracts 1.
- flush takes priority over push and pop in the same cycle. It sets both pointers and count to 0. The word offered on in_data in that cycle is discarded.
- Head fields are driven combinationally from the entry at rd_ptr (first-word fall-through). When out_valid = 0, all field and flag outputs are forced to 0.
- Classification of the head entry (with E = exponent, M = mantissa):
  - out_is_zero: E = 0 and M = 0
  - out_is_denorm: E = 0 and M != 0
  - out_is_inf: E all ones and M = 0
  - out_is_nan: E all ones and M != 0
  - At most one flag is high at a time.
- The storage array is not reset. Only the pointers and count are reset.

## Timing
- Reset (asynchronous assert): count = 0, pointers = 0, out_valid = 0, in_ready = 1, all field and flag outputs = 0.
- Latency: a word pushed at edge N into an empty FIFO appears on out_* with out_valid = 1 immediately after edge N, so it can be popped at edge N+1.
- Throughput: one push and one pop per cycle, sustained.
- A full FIFO drops in_ready after the edge that filled it. in_ready rises again after the first pop edge.
- Reset asserted mid-stream: all contents are lost immediately, without waiting for a clock edge. The first push after reset release is handled normally.

## Configuration
- FP_CLASSIFY_EN defined: the classification logic is built and the four out_is_* flags behave as specified under Operation.
- FP_CLASSIFY_EN undefined: no classification logic is built. The four out_is_* ports remain in the interface and are tied to 0. All other behaviour is identical.

## Test plan
- Reset then single word: push 32'h3F800000 -> the next cycle shows out_valid=1, out_sign=0, out_exponent=8'h7F, out_mantissa=0, count=1. A pop returns count=0 and out_valid=0.
- Fill and order: push 1..5 with out_ready=0 (DEPTH=4) -> in_ready=0 after the 4th push and the 5th word is refused. Draining yields words 1,2,3,4 in order.
- Simultaneous push and pop at count=2 for 10 cycles -> count stays 2, every word exits in order, and pointer wrap is exercised.
- Classification (FP_CLASSIFY_EN defined): head 32'h00000000 -> zero; 32'h00000001 -> denorm; 32'h7F800000 -> inf; 32'h7FC00000 -> nan. Each shows exactly one flag. With the macro undefined, all flags stay 0.
- Flush with push: count=3, flush=1 and in_valid=1 in the same cycle -> count=0, out_valid=0, and the offered word is discarded.
- Asynchronous reset mid-cycle with count=2 -> count=0 and out_valid=0 before the next clock edge. Use EXP_W=5, MAN_W=10 for a half-precision regression of the fill and order scenario.
